// File: rtl/lsu_ctrl.sv
// lsu_ctrl
// -----------------------------------------------------------------------------
// Load/store unit between the RV32i execute stage and a variable-latency data
// memory. It accepts one memory op at a time from execute. For each op it:
//   - decodes the access width and signedness from funct3,
//   - generates byte enables and lane-replicated store data,
//   - runs a req/ack handshake with the memory,
//   - extends load data,
//   - raises precise exceptions for illegal width, misalignment, out-of-range
//     addresses and memory timeout.
//
// Parameters
//   ADDR_WIDTH  word-address bits of the data memory (window = 2^(ADDR_WIDTH+2) B)
//   BASE_ADDR   byte address of data memory word 0
//   TIMEOUT     unacknowledged WAIT cycles before an access fault (0 = never)
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   ex_valid / ex_ready           op handshake from execute (ready only in IDLE)
//   ex_is_store, ex_funct3        op kind and RV32i width/sign code
//   ex_addr, ex_wdata, ex_rd      effective address, store data, load target
//   mem_req, mem_we, mem_be       registered memory request, write strobe, lanes
//   mem_addr, mem_wdata           word address and lane-replicated write data
//   mem_ack, mem_rdata            memory completion and read word
//   wb_valid, wb_we, wb_rd, wb_data  one-cycle completion / load writeback
//   exc_valid, exc_cause, exc_addr   one-cycle exception with mcause and mtval
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [31:0]           ex_addr,
    input  logic [31:0]           ex_wdata,
    input  logic [4:0]            ex_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  exc_valid,
    output logic [3:0]            exc_cause,
    output logic [31:0]           exc_addr
);

    // The window end is computed one bit wider so that a window ending
    // exactly at 2^32 still compares correctly.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_WIDTH + 2));

    // The counter only ever needs to hold 0..TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_EXC
    } state_t;

    state_t          state_q;
    logic [31:0]     opAddr_q;
    logic [2:0]      opFunct3_q;
    logic            opStore_q;
    logic [4:0]      opRd_q;
    logic [CNT_W-1:0] cnt_q;

    logic                  isHalf;
    logic                  isWord;
    logic                  illegalOp;
    logic                  misaligned;
    logic                  outOfRange;
    logic                  accFault;
    logic [3:0]            accCause;
    logic [3:0]            accBe;
    logic [31:0]           accWdata;
    logic [ADDR_WIDTH-1:0] accWordAddr;
    logic [15:0]           laneData;
    logic [31:0]           loadData;
    logic                  timeoutHit;

    assign ex_ready = (state_q == S_IDLE);

    // Decode the op currently offered by execute. The fault checks are
    // prioritised: illegal width beats misalignment, which beats range.
    // Loads carry no write data, so their wdata is simply left at zero.
    always_comb begin
        isHalf     = (ex_funct3[1:0] == 2'b01);
        isWord     = (ex_funct3[1:0] == 2'b10);
        if (ex_is_store) begin
            illegalOp = (ex_funct3 > 3'd2);
        end else begin
            illegalOp = (ex_funct3 == 3'd3) || (ex_funct3[2:1] == 2'b11);
        end
        misaligned  = (isHalf && ex_addr[0]) || (isWord && (ex_addr[1:0] != 2'b00));
        outOfRange  = (ex_addr < BASE_ADDR) || ({1'b0, ex_addr} >= WIN_END);
        accFault    = illegalOp || misaligned || outOfRange;
        accWordAddr = ADDR_WIDTH'((ex_addr - BASE_ADDR) >> 2);

        accCause = 4'd0;
        if (illegalOp) begin
            accCause = 4'd2;
        end else if (misaligned) begin
            accCause = ex_is_store ? 4'd6 : 4'd4;
        end else if (outOfRange) begin
            accCause = ex_is_store ? 4'd7 : 4'd5;
        end

        accBe    = 4'hF;
        accWdata = 32'h0;
        if (ex_is_store) begin
            if (isWord) begin
                accWdata = ex_wdata;
            end else if (isHalf) begin
                accBe    = 4'b0011 << ex_addr[1:0];
                accWdata = {2{ex_wdata[15:0]}};
            end else begin
                accBe    = 4'b0001 << ex_addr[1:0];
                accWdata = {4{ex_wdata[7:0]}};
            end
        end
    end

    // Select the addressed lane of the read word and extend it. Only the
    // low halfword after the shift is ever needed for sub-word loads.
    always_comb begin
        laneData = 16'(mem_rdata >> {opAddr_q[1:0], 3'b000});
        case (opFunct3_q)
            3'd0:    loadData = {{24{laneData[7]}}, laneData[7:0]};
            3'd1:    loadData = {{16{laneData[15]}}, laneData};
            3'd4:    loadData = {24'h0, laneData[7:0]};
            3'd5:    loadData = {16'h0, laneData};
            default: loadData = mem_rdata;
        endcase
    end

    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Main controller. All handshake outputs are registered here so that
    // mem_* stay stable for the whole WAIT phase. wb_valid and exc_valid
    // are set only on the transition into RESP or EXC, which makes them
    // one-cycle pulses that can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opAddr_q   <= 32'h0;
            opFunct3_q <= 3'd0;
            opStore_q  <= 1'b0;
            opRd_q     <= 5'd0;
            cnt_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'h0;
            exc_valid  <= 1'b0;
            exc_cause  <= 4'd0;
            exc_addr   <= 32'h0;
        end else begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            exc_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        opAddr_q   <= ex_addr;
                        opFunct3_q <= ex_funct3;
                        opStore_q  <= ex_is_store;
                        opRd_q     <= ex_rd;
                        cnt_q      <= '0;
                        if (accFault) begin
                            state_q   <= S_EXC;
                            exc_valid <= 1'b1;
                            exc_cause <= accCause;
                            exc_addr  <= ex_addr;
                        end else begin
                            state_q   <= S_WAIT;
                            mem_req   <= 1'b1;
                            mem_we    <= ex_is_store;
                            mem_be    <= accBe;
                            mem_addr  <= accWordAddr;
                            mem_wdata <= accWdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state_q   <= S_RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'h0;
                        mem_addr  <= '0;
                        mem_wdata <= 32'h0;
                        wb_valid  <= 1'b1;
                        wb_we     <= ~opStore_q;
                        wb_rd     <= opRd_q;
                        if (!opStore_q) begin
                            wb_data <= loadData;
                        end
                    end else if (timeoutHit) begin
                        state_q   <= S_EXC;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'h0;
                        mem_addr  <= '0;
                        mem_wdata <= 32'h0;
                        exc_valid <= 1'b1;
                        exc_cause <= opStore_q ? 4'd7 : 4'd5;
                        exc_addr  <= opAddr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                S_EXC:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for lsu_ctrl with default parameters. A behavioural
// model computes fault causes, byte enables, replicated store data and
// extended load results arithmetically. A word array plays the data memory.
// Directed cases are followed by a randomized op stream.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int          AW      = 10;
    localparam logic [31:0] BASE    = 32'h0;
    localparam int          TMO     = 15;
    localparam int          WORDS   = 1 << AW;
    localparam logic [31:0] WINDOW  = 32'(4 * WORDS);

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic          ex_is_store;
    logic [2:0]    ex_funct3;
    logic [31:0]   ex_addr;
    logic [31:0]   ex_wdata;
    logic [4:0]    ex_rd;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          wb_valid;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          exc_valid;
    logic [3:0]    exc_cause;
    logic [31:0]   exc_addr;

    int numChecks = 0;
    int numPassed = 0;

    logic [31:0] memModel [WORDS];

    lsu_ctrl #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_is_store(ex_is_store),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr)
    );

    // 100 MHz clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            numPassed++;
        end
    endtask

    // Access size in bytes implied by funct3.
    function automatic int opSize(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Expected mcause for an op at accept time; 0 means no fault.
    function automatic logic [3:0] refCause(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal)                                     return 4'd2;
        if ((addr % 32'(opSize(f3))) != 0)              return st ? 4'd6 : 4'd4;
        if (addr < BASE || (addr - BASE) >= WINDOW)     return st ? 4'd7 : 4'd5;
        return 4'd0;
    endfunction

    // Expected load result: pick the lane arithmetically, then extend.
    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] word, input int off);
        logic [31:0] sh;
        int v;
        sh = word >> (8 * off);
        case (f3)
            3'd0: begin v = int'(sh % 256);   if (v >= 128)   v -= 256;   end
            3'd1: begin v = int'(sh % 65536); if (v >= 32768) v -= 65536; end
            3'd4: v = int'(sh % 256);
            3'd5: v = int'(sh % 65536);
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] refWdata(input int size, input logic [31:0] wd);
        if (size == 1) return (wd % 256) * 32'h01010101;
        if (size == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // Drives one op from an idle falling edge, plays the memory with the
    // given number of wait cycles, and checks every cycle until the LSU is
    // idle again. Returns on a falling edge with the LSU back in IDLE.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [4:0] rd, input int ackDelay);
        logic [3:0]  cause;
        logic [31:0] expBe;
        logic [31:0] expWd;
        logic [31:0] mask;
        int size;
        int off;
        int idx;
        int cyc;
        bit finished;

        cause = refCause(st, f3, addr);
        size  = opSize(f3);
        off   = int'(addr % 4);
        idx   = int'((addr - BASE) / 4) % WORDS;
        expBe = 32'(((1 << size) - 1) << off);
        expWd = refWdata(size, wd);

        checkOutput("ready_idle", ex_ready, 1);
        ex_valid    = 1'b1;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = addr;
        ex_wdata    = wd;
        ex_rd       = rd;
        @(negedge clk);
        ex_valid = 1'b0;
        ex_addr  = $urandom;
        ex_wdata = $urandom;
        ex_rd    = 5'($urandom);

        if (cause != 4'd0) begin
            checkOutput("exc_valid", exc_valid, 1);
            checkOutput("exc_cause", exc_cause, cause);
            checkOutput("exc_addr", exc_addr, addr);
            checkOutput("exc_no_req", mem_req, 0);
            checkOutput("exc_no_wb", wb_valid, 0);
        end else begin
            cyc      = 1;
            finished = 0;
            while (!finished) begin
                checkOutput("req_high", mem_req, 1);
                checkOutput("req_we", mem_we, st);
                checkOutput("req_be", mem_be, st ? expBe : 32'hF);
                checkOutput("req_addr", mem_addr, 32'(idx));
                if (st) checkOutput("req_wdata", mem_wdata, expWd);
                checkOutput("busy_not_ready", ex_ready, 0);
                if (cyc - 1 == ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = st ? $urandom : memModel[idx];
                    @(negedge clk);
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    checkOutput("wb_valid", wb_valid, 1);
                    checkOutput("wb_we", wb_we, !st);
                    checkOutput("wb_rd", wb_rd, rd);
                    if (!st) checkOutput("wb_data", wb_data, refLoad(f3, memModel[idx], off));
                    checkOutput("wb_no_exc", exc_valid, 0);
                    checkOutput("wb_req_low", mem_req, 0);
                    if (st) begin
                        mask = 32'h0;
                        for (int b = 0; b < 4; b++) if (expBe[b]) mask |= 32'hFF << (8 * b);
                        memModel[idx] = (memModel[idx] & ~mask) | (expWd & mask);
                    end
                    finished = 1;
                end else if (cyc == TMO || cyc > 200) begin
                    @(negedge clk);
                    checkOutput("tmo_exc_valid", exc_valid, 1);
                    checkOutput("tmo_exc_cause", exc_cause, st ? 32'd7 : 32'd5);
                    checkOutput("tmo_exc_addr", exc_addr, addr);
                    checkOutput("tmo_req_low", mem_req, 0);
                    checkOutput("tmo_no_wb", wb_valid, 0);
                    finished = 1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        @(negedge clk);
        checkOutput("wb_pulse_end", wb_valid, 0);
        checkOutput("exc_pulse_end", exc_valid, 0);
        checkOutput("ready_again", ex_ready, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3   = 3'd0;
        ex_addr     = 32'h0;
        ex_wdata    = 32'h0;
        ex_rd       = 5'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        for (int i = 0; i < WORDS; i++) memModel[i] = $urandom;
        memModel[2] = 32'h80FF7F01;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", ex_ready, 1);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_be", mem_be, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_we", wb_we, 0);
        checkOutput("rst_wb_rd", wb_rd, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_exc_valid", exc_valid, 0);
        checkOutput("rst_exc_cause", exc_cause, 0);
        checkOutput("rst_exc_addr", exc_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loads from the word 0x80FF7F01 at byte 0x8, zero wait states.
        applyStimulus(1'b0, 3'd0, 32'h9, 32'h0, 5'd1, 0);
        applyStimulus(1'b0, 3'd0, 32'hA, 32'h0, 5'd2, 0);
        applyStimulus(1'b0, 3'd1, 32'hA, 32'h0, 5'd3, 0);
        applyStimulus(1'b0, 3'd5, 32'hA, 32'h0, 5'd4, 0);
        applyStimulus(1'b0, 3'd2, 32'h8, 32'h0, 5'd5, 0);

        // Stores with lane replication.
        applyStimulus(1'b1, 3'd0, 32'h13, 32'hA1B2C3D4, 5'd6, 0);
        applyStimulus(1'b1, 3'd1, 32'h12, 32'hA1B2C3D4, 5'd7, 0);
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hA1B2C3D4, 5'd8, 0);

        // Faults detected at accept.
        applyStimulus(1'b0, 3'd2, 32'h6, 32'h0, 5'd9, 0);
        applyStimulus(1'b1, 3'd1, 32'h5, 32'h0, 5'd9, 0);
        applyStimulus(1'b0, 3'd3, 32'h40, 32'h0, 5'd9, 0);
        applyStimulus(1'b0, 3'd2, 32'h1000, 32'h0, 5'd9, 0);
        applyStimulus(1'b1, 3'd5, 32'h40, 32'h0, 5'd9, 0);
        applyStimulus(1'b0, 3'd2, 32'hFFC, 32'h0, 5'd10, 0);

        // Wait states, then a timeout followed by a spurious ack.
        applyStimulus(1'b0, 3'd2, 32'h8, 32'h0, 5'd11, 3);
        applyStimulus(1'b0, 3'd2, 32'h8, 32'h0, 5'd11, TMO - 1);
        applyStimulus(1'b1, 3'd2, 32'h0, 32'h12345678, 5'd12, 1000);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("spurious_wb", wb_valid, 0);
        checkOutput("spurious_exc", exc_valid, 0);
        checkOutput("spurious_req", mem_req, 0);
        checkOutput("spurious_ready", ex_ready, 1);

        // Reset asserted in the second WAIT cycle drops the request at once.
        ex_valid  = 1'b1;
        ex_is_store = 1'b0;
        ex_funct3 = 3'd2;
        ex_addr   = 32'h20;
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput("midrst_req_before", mem_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", mem_req, 0);
        checkOutput("midrst_ready", ex_ready, 1);
        checkOutput("midrst_be", mem_be, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 5'd13, 1);

        // Randomized op stream, mostly in range with short waits.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int d;
            a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(32'h1000, 32'h1100))
                                             : 32'($urandom_range(0, 32'hFFF));
            d = ($urandom_range(0, 19) == 0) ? 40 : int'($urandom_range(0, 3));
            applyStimulus(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom), d);
        end

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store unit between the RV32i execute stage and the data memory. It decodes RV32i load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW), generates byte enables and lane-replicated write data, and sign- or zero-extends load data. It runs a request/acknowledge handshake with a variable-latency data memory and raises precise exceptions for illegal width, misalignment, out-of-range address and memory timeout. It replaces the fixed single-cycle word access of the current data path.

## Interface
- ADDR_WIDTH, 10: word-address bits of the data memory; the window is 2^(ADDR_WIDTH+2) bytes.
- BASE_ADDR, 32'h0: byte address of data memory word 0.
- TIMEOUT, 15: cycles mem_req may stay unacknowledged before an access fault; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute stage presents a memory op.
- ex_ready  out  1  LSU accepts the op (high only in IDLE).
- ex_is_store  in  1  1 = store, 0 = load.
- ex_funct3  in  3  RV32i funct3 width/sign code.
- ex_addr  in  32  effective byte address.
- ex_wdata  in  32  store data (rs2).
- ex_rd  in  5  load destination register.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory completes the access in this cycle.
- mem_rdata  in  32  read word, valid when mem_ack=1.
- wb_valid  out  1  one-cycle pulse: load result or store done.
- wb_we  out  1  1 = write wb_data to wb_rd (loads only).
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load data.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  4  RISC-V mcause code: 2 illegal, 4/6 load/store misaligned, 5/7 load/store access fault.
- exc_addr  out  32  faulting byte address (mtval).

## Operation
- States: IDLE, WAIT, RESP, EXC.
- IDLE: ex_ready=1. On ex_valid, latch the op and check in priority order:
  1. Illegal funct3: loads 3/6/7; stores 3–7 → cause 2.
  2. Misaligned: halfword with addr[0]≠0, word with addr[1:0]≠0 → cause 4 (load) or 6 (store).
  3. Out of range: addr < BASE_ADDR or addr ≥ BASE_ADDR + 2^(ADDR_WIDTH+2) → cause 5 or 7.
- Any fault → EXC; otherwise → WAIT.
- WAIT:
  - Outputs: mem_req=1, mem_addr=(addr−BASE_ADDR)[ADDR_WIDTH+1:2], off=addr[1:0].
  - Stores: mem_we=1. Byte: be=4'b0001<<off, wdata={4{wdata[7:0]}}. Half: be=4'b0011<<off, wdata={2{wdata[15:0]}}. Word: be=4'hF.
  - Loads: mem_we=0, be=4'hF.
  - On mem_ack → RESP. Load data is selected from lane off and extended: funct3 0/1 sign-extend, 4/5 zero-extend, 2 whole word. It is registered into wb_data.
  - Timeout counter: cleared on WAIT entry, incremented each WAIT cycle without ack. When it reaches TIMEOUT (TIMEOUT≠0) → EXC with cause 5/7. mem_req is low in EXC.
- RESP: wb_valid=1, wb_we=~store, wb_rd=latched rd. Next state is IDLE.
- EXC: exc_valid=1, exc_cause, exc_addr=latched addr. wb_valid=0. Next state is IDLE.
- mem_ack outside WAIT is ignored. mem_rdata is sampled only on an acked cycle.

## Timing
- Reset (async): state IDLE. ex_ready=1. All other outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_*, exc_*. Assertion mid-WAIT drops mem_req immediately and the op is discarded.
- Op accepted at edge 0 → mem_req high from cycle 1. With ack in cycle 1: wb_valid in cycle 2, ex_ready high in cycle 3. Minimum 3 cycles per op.
- Each ack-wait cycle adds one cycle of latency.
- Fault detected at accept: exc_valid in cycle 1, ex_ready in cycle 2.
- Timeout: mem_req stays high TIMEOUT cycles (cycles 1..TIMEOUT); exc_valid in cycle TIMEOUT+1.
- mem_* outputs are registered and stable throughout WAIT.
- wb_valid and exc_valid are never high together. Each is exactly one cycle per op.

## Test plan
- Memory word at byte 0x8 = 0x80FF7F01, ack with zero wait:
  - LB 0x9 → wb_data 0x0000007F.
  - LB 0xA → 0xFFFFFFFF.
  - LH 0xA → 0xFFFF80FF.
  - LHU 0xA → 0x000080FF.
  - LW 0x8 → 0x80FF7F01.
  - Each: wb_valid two cycles after accept, wb_we=1.
- Stores, ex_wdata=0xA1B2C3D4:
  - SB 0x13 → mem_addr 4, be 4'b1000, wdata 0xD4D4D4D4.
  - SH 0x12 → be 4'b1100, wdata 0xC3D4C3D4.
  - SW 0x10 → be 4'hF.
  - Each: wb_valid with wb_we=0.
- Faults:
  - LW 0x6 → exc_cause 4, exc_addr 0x6.
  - SH 0x5 → 6.
  - funct3=3 load → 2.
  - LW at 0x1000 (ADDR_WIDTH=10) → 5.
  - mem_req never asserted for any of these.
- Wait states: ack 3 cycles after mem_req rises → wb_valid in cycle 5. Signals held stable meanwhile.
- Timeout: TIMEOUT=15, ack never arrives on SW 0x0 → mem_req high cycles 1–15, exc_valid cycle 16 with cause 7. A spurious ack afterwards is ignored.
- Reset mid-WAIT: rst_n low during cycle 2 → mem_req 0 asynchronously, ex_ready 1. After release, a new LW completes normally.
